switch_debounce_sync: RTL and testbench

- Upstream input-conditioning stage for the LED pattern controller `main`.
- Takes the two raw, asynchronous, bouncy board switches and produces clean, glitch-free mode levels that drive main's S0/S1 inputs.
- Also produces single-cycle press and mode-change strobes.
- Shares main's clock (clki) and reset (rs).

---
 rtl/switch_debounce_sync.sv | 90 +++++++++
 tb/tb_switch_debounce_sync.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/switch_debounce_sync.sv
// Two-channel switch conditioner: 2-flop synchronizer, counter debounce, rise/change strobes.
// Define SWDB_TOGGLE_EN to turn S0/S1 into press-to-toggle outputs instead of level followers.
module switch_debounce_sync #(
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = 20
) (
  input  logic clki,
  input  logic rs,
  input  logic sw0_raw,
  input  logic sw1_raw,
  output logic S0,
  output logic S1,
  output logic s0_rise,
  output logic s1_rise,
  output logic chg
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       ff1_r;
  logic [1:0]       ff2_r;
  logic [1:0]       stable_r;
  logic [1:0]       out_r;
  logic [1:0]       rise_r;
  logic             chg_r;
  logic [CNT_W-1:0] cnt_r     [2];

  logic [CNT_W-1:0] cnt_nxt_s [2];
  logic [1:0]       accept_s;
  logic [1:0]       stable_nxt_s;
  logic [1:0]       press_s;
  logic [1:0]       out_nxt_s;
  logic             chg_nxt_s;

  // Per-channel debounce counter and the next debounced/output state.
  always_comb begin
    accept_s = 2'b00;
    for (int ch = 0; ch < 2; ch++) begin
      cnt_nxt_s[ch] = {CNT_W{1'b0}};
      if (ff2_r[ch] == stable_r[ch]) begin
        cnt_nxt_s[ch] = {CNT_W{1'b0}};
      end else if (cnt_r[ch] == CNT_MAX) begin
        cnt_nxt_s[ch] = {CNT_W{1'b0}};
        accept_s[ch]  = 1'b1;
      end else begin
        cnt_nxt_s[ch] = cnt_r[ch] + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
    stable_nxt_s = stable_r ^ accept_s;
    press_s      = accept_s & ff2_r;
`ifdef SWDB_TOGGLE_EN
    // Only presses matter; releases update the tracked level but not the output.
    out_nxt_s = out_r ^ press_s;
    chg_nxt_s = |press_s;
`else
    out_nxt_s = stable_nxt_s;
    chg_nxt_s = |accept_s;
`endif
  end

  // Synchronizers, counters and registered outputs, all cleared by rs.
  always_ff @(posedge clki) begin
    if (rs) begin
      ff1_r    <= 2'b00;
      ff2_r    <= 2'b00;
      stable_r <= 2'b00;
      out_r    <= 2'b00;
      rise_r   <= 2'b00;
      chg_r    <= 1'b0;
      cnt_r[0] <= {CNT_W{1'b0}};
      cnt_r[1] <= {CNT_W{1'b0}};
    end else begin
      ff1_r    <= {sw1_raw, sw0_raw};
      ff2_r    <= ff1_r;
      stable_r <= stable_nxt_s;
      out_r    <= out_nxt_s;
      rise_r   <= press_s;
      chg_r    <= chg_nxt_s;
      cnt_r[0] <= cnt_nxt_s[0];
      cnt_r[1] <= cnt_nxt_s[1];
    end
  end

  assign S0      = out_r[0];
  assign S1      = out_r[1];
  assign s0_rise = rise_r[0];
  assign s1_rise = rise_r[1];
  assign chg     = chg_r;

endmodule

// File: tb/tb_switch_debounce_sync.sv
// Scoreboard bench for switch_debounce_sync with DEB_CYCLES=4; toggle checks need SWDB_TOGGLE_EN.
module tb_switch_debounce_sync;

  localparam int DEB = 4;
  localparam int LAT = DEB + 2;

  logic clki = 1'b0;
  logic rs, sw0_raw, sw1_raw;
  logic S0, S1, s0_rise, s1_rise, chg;

  switch_debounce_sync #(.DEB_CYCLES(DEB), .CNT_W(4)) dut (
    .clki(clki), .rs(rs), .sw0_raw(sw0_raw), .sw1_raw(sw1_raw),
    .S0(S0), .S1(S1), .s0_rise(s0_rise), .s1_rise(s1_rise), .chg(chg)
  );

  always #5 clki = ~clki;

  typedef struct {
    int   at;
    logic s0, s1, r0, r1;
  } ev_t;

  ev_t q[$];
  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;
  logic rs_q = 1'b1;
  logic started = 1'b0;
  logic ps0 = 1'b0, ps1 = 1'b0;

  // Reference model state: debounced levels and outputs.
  bit lvl0, lvl1, out0, out1;

  always @(posedge clki) begin
    cyc  <= cyc + 1;
    rs_q <= rs;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clki);
  endtask

  task automatic model_reset();
    lvl0 = 1'b0; lvl1 = 1'b0; out0 = 1'b0; out1 = 1'b0;
  endtask

  // Record an accepted debounced transition and queue the visible event, if any.
  task automatic accept(input int at, input bit a0, input bit a1, input bit n0, input bit n1);
    bit r0, r1, c;
    ev_t e;
    r0 = a0 & n0;
    r1 = a1 & n1;
    if (a0) lvl0 = n0;
    if (a1) lvl1 = n1;
`ifdef SWDB_TOGGLE_EN
    out0 = out0 ^ r0;
    out1 = out1 ^ r1;
    c = r0 | r1;
`else
    out0 = lvl0;
    out1 = lvl1;
    c = a0 | a1;
`endif
    if (c | r0 | r1) begin
      e.at = at; e.s0 = out0; e.s1 = out1; e.r0 = r0; e.r1 = r1;
      q.push_back(e);
    end
  endtask

  task automatic check_zero(input string name);
    total++;
    if ({S0, S1, s0_rise, s1_rise, chg} !== 5'b00000) begin
      bad++;
      $display("FAIL %s: got S=%b%b rise=%b%b chg=%b, expected all 0", name, S0, S1, s0_rise, s1_rise, chg);
    end
  endtask

  // Monitor: pops expected events on strobes and checks S changes only with chg.
  always @(negedge clki) begin
    if (started && !rs_q) begin
      total++;
      if (chg !== ((S0 !== ps0) || (S1 !== ps1))) begin
        bad++;
        $display("FAIL chg_vs_level: cyc=%0d chg=%b S=%b%b prev=%b%b", cyc, chg, S0, S1, ps0, ps1);
      end
      if (chg === 1'b1 || s0_rise === 1'b1 || s1_rise === 1'b1) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_event: cyc=%0d S=%b%b rise=%b%b chg=%b, expected none", cyc, S0, S1, s0_rise, s1_rise, chg);
        end else begin
          ev_t e;
          e = q.pop_front();
          if (cyc != e.at || S0 !== e.s0 || S1 !== e.s1 || s0_rise !== e.r0 || s1_rise !== e.r1 || chg !== 1'b1) begin
            bad++;
            $display("FAIL event: got cyc=%0d S=%b%b rise=%b%b chg=%b, expected cyc=%0d S=%b%b rise=%b%b chg=1",
                     cyc, S0, S1, s0_rise, s1_rise, chg, e.at, e.s0, e.s1, e.r0, e.r1);
          end
        end
      end
    end
    ps0 = S0;
    ps1 = S1;
  end

  initial begin
    bit pat [9];
    int n;
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    rs = 1'b1; sw0_raw = 1'b0; sw1_raw = 1'b0;
    model_reset();
    @(posedge clki);
    started = 1'b1;
    tick(2);
    check_zero("reset_state");
    rs = 1'b0;

    // Single press on channel 0.
    n = cyc; sw0_raw = 1'b1; accept(n + LAT, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(10);

    // Three-cycle glitch on channel 1 is rejected, then a held press is accepted.
    sw1_raw = 1'b1; tick(3); sw1_raw = 1'b0; tick(10);
    n = cyc; sw1_raw = 1'b1; accept(n + LAT, 1'b0, 1'b1, 1'b0, 1'b1);
    tick(10);

    // Simultaneous release, then simultaneous press.
    n = cyc; sw0_raw = 1'b0; sw1_raw = 1'b0; accept(n + LAT, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(10);
    n = cyc; sw0_raw = 1'b1; sw1_raw = 1'b1; accept(n + LAT, 1'b1, 1'b1, 1'b1, 1'b1);
    tick(10);

    // Reset during a pending release count, raws high again through reset.
    sw0_raw = 1'b0; sw1_raw = 1'b0; tick(3);
    rs = 1'b1; sw0_raw = 1'b1; sw1_raw = 1'b1; tick(1);
    check_zero("reset_mid_count");
    model_reset();
    rs = 1'b0;
    n = cyc; accept(n + LAT, 1'b1, 1'b1, 1'b1, 1'b1);
    tick(10);

    // Release, then bouncy press on channel 0 settling after the last steady run.
    n = cyc; sw0_raw = 1'b0; sw1_raw = 1'b0; accept(n + LAT, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(10);
    n = cyc; accept(n + 5 + LAT, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      sw0_raw = pat[i];
      tick(1);
    end
    tick(12);

`ifdef SWDB_TOGGLE_EN
    // Release, press, release, press: output toggles once per press.
    for (int k = 0; k < 2; k++) begin
      n = cyc; sw0_raw = 1'b0; accept(n + LAT, 1'b1, 1'b0, 1'b0, 1'b0);
      tick(10);
      n = cyc; sw0_raw = 1'b1; accept(n + LAT, 1'b1, 1'b0, 1'b1, 1'b0);
      tick(10);
    end
`endif

    tick(2);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL missing_events: got %0d pending, expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
